// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU op codes, FSM encodings and control bundle for the
// execute stage.
package ex_stage_pkg;

    // Datapath widths
    localparam int REG_DATA_W = 32;
    localparam int ALU_W      = 4;
    localparam int SHAMT_BITS = 5;

    // ALU op codes
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SLL = 4'd5;
    localparam logic [ALU_W-1:0] ALU_SRL = 4'd6;
    localparam logic [ALU_W-1:0] ALU_SRA = 4'd7;
    localparam logic [ALU_W-1:0] ALU_LUI = 4'd8;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'd9;

    // FSM state encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Memory / write-back controls carried into EX/MEM
    typedef struct packed {
        logic write_reg;
        logic mem_to_reg;
        logic write_mem;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_NONE = '{write_reg: 1'b0, mem_to_reg: 1'b0, write_mem: 1'b0};

endpackage

// File: rtl/ex_stage_serial_shifter.sv
// Serial 1-bit-per-cycle shifter. Loads a value, op and amount, then shifts
// the accumulator one position per run cycle. step_o is the value the next
// shift produces, so the owner can capture the final result on the same
// edge that performs the last shift (done_o high).
module serial_shifter
    import ex_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ALUC_W  = 4,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               run_i,
    input  logic               abort_i,
    input  logic [ALUC_W-1:0]  op_i,
    input  logic [DATA_W-1:0]  val_i,
    input  logic [SHAMT_W-1:0] amt_i,
    output logic [DATA_W-1:0]  step_o,
    output logic               done_o
);

    logic [DATA_W-1:0]  acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [ALUC_W-1:0]  op_q;

    // One-position shift of the accumulator according to the latched op
    always_comb begin
        step_o = acc_q;
        case (op_q)
            ALU_SLL: step_o = {acc_q[DATA_W-2:0], 1'b0};
            ALU_SRL: step_o = {1'b0, acc_q[DATA_W-1:1]};
            ALU_SRA: step_o = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
            default: step_o = acc_q;
        endcase
    end

    // Last shift happens on the edge that ends the cycle where the counter is 1
    assign done_o = run_i && (cnt_q == SHAMT_W'(1));

    // Accumulator / counter / op registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            op_q  <= '0;
        end else if (load_i) begin
            acc_q <= val_i;
            cnt_q <= amt_i;
            op_q  <= op_i;
        end else if (abort_i) begin
            cnt_q <= '0;
        end else if (run_i && cnt_q != '0) begin
            acc_q <= step_o;
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: inline single-cycle ALU plus a serial shifter for non-zero
// shift amounts, registered into the EX/MEM boundary. Upstream is stalled
// while a serial shift is running.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W  = REG_DATA_W,
    parameter int ALUC_W  = ALU_W,
    parameter int SHAMT_W = SHAMT_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              exe_write_reg,
    input  logic              exe_mem_to_reg,
    input  logic              exe_write_mem,
    input  logic [ALUC_W-1:0] exe_aluc,
    input  logic              exe_shift,
    input  logic              exe_alu_imm,
    input  logic [DATA_W-1:0] oprand_1_i,
    input  logic [DATA_W-1:0] oprand_2_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic              stall_o,
    output logic              mem_valid,
    output logic              mem_write_reg,
    output logic              mem_mem_to_reg,
    output logic              mem_write_mem,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] store_data
);

    logic [0:0]         state_q, state_d;

    // EX/MEM boundary registers
    logic               valid_q, valid_d;
    ex_ctrl_t           ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0]  sdata_q, sdata_d;

    // Controls and store data parked while a serial shift runs
    ex_ctrl_t           hold_ctrl_q, hold_ctrl_d;
    logic [DATA_W-1:0]  hold_sdata_q, hold_sdata_d;

    logic [DATA_W-1:0]  op_a, op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  alu_res;
    ex_ctrl_t           in_ctrl;

    logic               sh_load, sh_run, sh_abort, sh_done;
    logic [DATA_W-1:0]  sh_step;

    assign op_a    = oprand_1_i;
    assign op_b    = exe_alu_imm ? imm_i : oprand_2_i;
    assign shamt   = oprand_1_i[SHAMT_W-1:0];
    assign in_ctrl = '{write_reg: exe_write_reg, mem_to_reg: exe_mem_to_reg,
                       write_mem: exe_write_mem};

    // Single-cycle ALU. Shift codes only reach this path with a zero amount
    // (or without exe_shift), so they pass B through unchanged.
    always_comb begin
        alu_res = '0;
        case (exe_aluc)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA: alu_res = op_b;
            ALU_LUI: alu_res = op_b << 16;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_res = '0;
        endcase
    end

    assign sh_run  = (state_q == ST_SHIFT) && !flush;
    assign stall_o = (state_q == ST_SHIFT);

    serial_shifter #(
        .DATA_W  (DATA_W),
        .ALUC_W  (ALUC_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sh_load),
        .run_i   (sh_run),
        .abort_i (sh_abort),
        .op_i    (exe_aluc),
        .val_i   (op_b),
        .amt_i   (shamt),
        .step_o  (sh_step),
        .done_o  (sh_done)
    );

    // Next-state and EX/MEM load selection; a bubble is the default
    always_comb begin
        state_d      = state_q;
        valid_d      = 1'b0;
        ctrl_d       = CTRL_NONE;
        res_d        = '0;
        sdata_d      = '0;
        hold_ctrl_d  = hold_ctrl_q;
        hold_sdata_d = hold_sdata_q;
        sh_load      = 1'b0;
        sh_abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    if (exe_shift && shamt != '0) begin
                        sh_load      = 1'b1;
                        hold_ctrl_d  = in_ctrl;
                        hold_sdata_d = oprand_2_i;
                        state_d      = ST_SHIFT;
                    end else begin
                        valid_d = 1'b1;
                        ctrl_d  = in_ctrl;
                        res_d   = alu_res;
                        sdata_d = oprand_2_i;
                    end
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    sh_abort = 1'b1;
                    state_d  = ST_IDLE;
                end else if (sh_done) begin
                    valid_d = 1'b1;
                    ctrl_d  = hold_ctrl_q;
                    res_d   = sh_step;
                    sdata_d = hold_sdata_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, EX/MEM and parked-control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            ctrl_q       <= CTRL_NONE;
            res_q        <= '0;
            sdata_q      <= '0;
            hold_ctrl_q  <= CTRL_NONE;
            hold_sdata_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            res_q        <= res_d;
            sdata_q      <= sdata_d;
            hold_ctrl_q  <= hold_ctrl_d;
            hold_sdata_q <= hold_sdata_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_write_reg  = ctrl_q.write_reg;
    assign mem_mem_to_reg = ctrl_q.mem_to_reg;
    assign mem_write_mem  = ctrl_q.write_mem;
    assign alu_result     = res_q;
    assign store_data     = sdata_q;

endmodule
